// File: rtl/reg_dump_unit.sv
// reg_dump_unit
//   Walks register addresses 0..NUM_REGISTERS-1 on a start request, reads
//   each word through a combinational register-file read port and streams it
//   out most-significant byte first over a valid/ready byte interface.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   start         dump request, sampled only in IDLE
//   busy          high in every state other than IDLE
//   done          one-cycle pulse after the last byte is accepted
//   rf_read_add   registered register-file read address
//   rf_read_data  register-file read data (combinational from rf_read_add)
//   tx_data       byte to transmit
//   tx_valid      tx_data holds a valid byte
//   tx_ready      downstream accepts the byte this cycle
//
// States
//   IDLE | waiting for start
//   LOAD | capture rf_read_data into the shift register (one cycle)
//   SEND | present bytes MSB first until the whole word is accepted
//   DONE | one-cycle done pulse, then back to IDLE
module reg_dump_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int WIDTH_ADD     = 5,
  parameter int NUM_REGISTERS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH_ADD-1:0]  rf_read_add,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0]        LAST_BYTE = CW'(BYTES - 1);
  localparam logic [WIDTH_ADD-1:0] LAST_ADD  = WIDTH_ADD'(NUM_REGISTERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         byte_cnt;
  logic                  xfer;

  assign tx_data = shift_q[DATA_WIDTH-1 -: 8];

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    tx_valid  = (state == SEND);
    xfer      = (state == SEND) && tx_ready;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: begin
        if (xfer && (byte_cnt == LAST_BYTE)) begin
          state_nxt = (rf_read_add == LAST_ADD) ? DONE : LOAD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_read_add <= '0;
      shift_q     <= '0;
      byte_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) rf_read_add <= '0;
        LOAD: begin
          shift_q  <= rf_read_data;
          byte_cnt <= '0;
        end
        SEND: begin
          if (xfer) begin
            if (byte_cnt == LAST_BYTE) begin
              // The address stops at the last register; DONE keeps it there.
              if (rf_read_add != LAST_ADD) rf_read_add <= rf_read_add + 1'b1;
            end else begin
              shift_q  <= shift_q << 8;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit
//   Directed bench for reg_dump_unit: default 32-bit/32-register instance plus
//   a 16-bit/4-register instance, each fed by a small register-file array.
module tb_reg_dump_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rf_read_add;
  logic [31:0] rf_read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic        start2;
  logic        busy2;
  logic        done2;
  logic [4:0]  rf_read_add2;
  logic [15:0] rf_read_data2;
  logic [7:0]  tx_data2;
  logic        tx_valid2;
  logic        tx_ready2;

  logic [31:0] rf  [32];
  logic [15:0] rf2 [4];

  int total = 0;
  int bad   = 0;

  logic [7:0] got [$];
  logic [7:0] exp [$];
  int done_cnt;
  int done_cyc;
  int stall_err;

  always #5 clk = ~clk;

  assign rf_read_data  = rf[rf_read_add];
  assign rf_read_data2 = rf2[rf_read_add2[1:0]];

  reg_dump_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .rf_read_add  (rf_read_add),
    .rf_read_data (rf_read_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  reg_dump_unit #(.DATA_WIDTH(16), .WIDTH_ADD(5), .NUM_REGISTERS(4)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .start        (start2),
    .busy         (busy2),
    .done         (done2),
    .rf_read_add  (rf_read_add2),
    .rf_read_data (rf_read_data2),
    .tx_data      (tx_data2),
    .tx_valid     (tx_valid2),
    .tx_ready     (tx_ready2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    if (obs !== req) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, req);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | i;
  endtask

  task automatic build_exp(input logic [31:0] r3w, input logic [31:0] r10w);
    logic [31:0] w;
    exp.delete();
    for (int i = 0; i < 32; i++) begin
      w = 32'hA500_0000 | i;
      if (i == 3)  w = r3w;
      if (i == 10) w = r10w;
      for (int b = 0; b < 4; b++) exp.push_back(w[31-8*b -: 8]);
    end
  endtask

  task automatic compare_stream(input string tag);
    int nbad;
    nbad = 0;
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) begin
        if (nbad == 0) $display("first byte difference at %0d: got=%0h exp=%0h", i, got[i], exp[i]);
        nbad++;
      end
    chk({tag, "_bytes_wrong"}, nbad, 0);
  endtask

  // mode: 0 plain, 1 backpressure, 2 snapshot writes, 3 start while busy,
  // 4 reset during r7 byte 2
  task automatic run_dump(input int mode);
    int   cyc;
    bit   fired;
    bit   quit;
    logic pv, pr;
    logic [7:0] pd;
    got.delete();
    done_cnt = 0; done_cyc = 0; stall_err = 0;
    fired = 0; quit = 0; pv = 0; pr = 0; pd = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 1;
    while (!quit) begin
      if (mode == 1) tx_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
      else           tx_ready = 1'b1;
      if (pv && !pr && !(tx_valid && tx_data == pd)) stall_err++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      start = 1'b0;
      if (mode == 3 && !fired && tx_valid && rf_read_add == 5'd5) begin
        start = 1'b1;
        fired = 1;
      end
      if (mode == 2 && tx_valid && got.size() == 13) begin
        rf[3]  = 32'hFFFF_FFFF;
        rf[10] = 32'h1234_5678;
      end
      if (mode == 4 && tx_valid && got.size() == 30) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_tx_valid", tx_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_add", rf_read_add, 0);
        quit = 1;
      end else begin
        if (tx_valid && tx_ready) got.push_back(tx_data);
        pv = tx_valid; pr = tx_ready; pd = tx_data;
        if (done_cnt > 0 && cyc >= done_cyc + 6) quit = 1;
        else if (cyc >= 3000) begin
          chk("timeout", cyc, 0);
          quit = 1;
        end else begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    start = 1'b0;
    if (mode != 4) chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int cyc2;
    int d2_cnt;
    int d2_cyc;
    reset = 1'b1; start = 1'b0; tx_ready = 1'b0;
    start2 = 1'b0; tx_ready2 = 1'b1;
    preload();
    for (int i = 0; i < 4; i++) rf2[i] = 16'hBE00 + 16'(i);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_add", rf_read_add, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst2_busy", busy2, 0);

    // full dump
    build_exp(32'hA500_0003, 32'hA500_000A);
    run_dump(0);
    compare_stream("full");
    chk("full_done_cnt", done_cnt, 1);
    chk("full_done_cyc", done_cyc, 161);
    chk("full_last_add", rf_read_add, 31);

    // backpressure 1,0,0,1
    run_dump(1);
    compare_stream("bp");
    chk("bp_stall_err", stall_err, 0);
    chk("bp_done_cnt", done_cnt, 1);

    // snapshot
    preload();
    build_exp(32'hA500_0003, 32'h1234_5678);
    run_dump(2);
    compare_stream("snap");

    // start while busy
    preload();
    build_exp(32'hA500_0003, 32'hA500_000A);
    run_dump(3);
    compare_stream("busy_start");
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_done_cyc", done_cyc, 161);

    // reset mid-dump, then clean dump
    run_dump(4);
    repeat (2) @(negedge clk);
    chk("rst_idle_busy", busy, 0);
    run_dump(0);
    compare_stream("after_rst");
    chk("after_rst_done_cyc", done_cyc, 161);

    // 16-bit / 4-register variant
    got.delete();
    exp.delete();
    for (int i = 0; i < 4; i++) begin
      exp.push_back(8'hBE);
      exp.push_back(8'(i));
    end
    d2_cnt = 0; d2_cyc = 0;
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    for (cyc2 = 1; cyc2 <= 20; cyc2++) begin
      if (done2) begin d2_cnt++; d2_cyc = cyc2; end
      if (tx_valid2 && tx_ready2) got.push_back(tx_data2);
      @(negedge clk);
    end
    compare_stream("w16");
    chk("w16_done_cnt", d2_cnt, 1);
    chk("w16_done_cyc", d2_cyc, 13);
    chk("w16_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
